// File: rtl/nor_from_nand.sv
// Bitwise 2-input NOR built only from 2-input NAND cells, with a registered copy,
// a saturating output-transition counter and an optional self-check (NOR_SELFCHECK_EN).
module nor_from_nand #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] tog_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] na;
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] or_n;

    // Four NAND cells per lane: invert each operand, NAND them into an OR, invert that.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        nand u_na  (na[i],   in1[i],  in1[i]);
        nand u_nb  (nb[i],   in2[i],  in2[i]);
        nand u_or  (or_n[i], na[i],   nb[i]);
        nand u_out (out[i],  or_n[i], or_n[i]);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the reset branch is asynchronous and wins over the clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            tog_cnt <= '0;
        end else begin
            out_q <= out;
            // Any number of lanes changing on one edge is a single transition.
            if (out != out_q && tog_cnt != CNT_MAX) begin
                tog_cnt <= tog_cnt + CNT_W'(1);
            end
        end
    end

`ifdef NOR_SELFCHECK_EN
    logic [WIDTH-1:0] ref_nor;
    logic [WIDTH-1:0] mismatch;
    logic             err_q;

    always_comb begin
        ref_nor  = ~(in1 | in2);
        mismatch = ref_nor ^ out;
    end

    function automatic int first_lane(input logic [WIDTH-1:0] m);
        int idx;
        idx = -1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (m[i]) idx = i;
        end
        return idx;
    endfunction

    // Sticky until reset; only the first mismatch is reported.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (mismatch != '0) begin
            err_q <= 1'b1;
            if (!err_q) begin
                $error("nor_from_nand: self-check mismatch on lane %0d", first_lane(mismatch));
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nor_from_nand.sv
// Randomized self-checking bench for nor_from_nand: a wide instance and a narrow
// instance with a 2-bit counter, both compared against a behavioural reference model.
module tb_nor_from_nand;

    localparam int W   = 8;
    localparam int CW  = 8;
    localparam int SW  = 1;
    localparam int SCW = 2;

    logic          clk = 1'b0;
    logic          rst;

    logic [W-1:0]  a_in1, a_in2, a_out, a_q;
    logic [CW-1:0] a_cnt;
    logic          a_err;

    logic [SW-1:0]  s_in1, s_in2, s_out, s_q;
    logic [SCW-1:0] s_cnt;
    logic           s_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0]  m_q;
    int            m_cnt;
    logic [SW-1:0] ms_q;
    int            ms_cnt;

    nor_from_nand #(.WIDTH(W), .CNT_W(CW)) u_wide (
        .clk(clk), .rst(rst), .in1(a_in1), .in2(a_in2),
        .out(a_out), .out_q(a_q), .tog_cnt(a_cnt), .err(a_err)
    );

    nor_from_nand #(.WIDTH(SW), .CNT_W(SCW)) u_sat (
        .clk(clk), .rst(rst), .in1(s_in1), .in2(s_in2),
        .out(s_out), .out_q(s_q), .tog_cnt(s_cnt), .err(s_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // A lane is 1 only when both operand bits are zero.
    function automatic logic [W-1:0] ref_nor_w(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = ((int'(a[i]) + int'(b[i])) == 0);
        return r;
    endfunction

    function automatic logic [SW-1:0] ref_nor_s(input logic [SW-1:0] a, input logic [SW-1:0] b);
        logic [SW-1:0] r;
        for (int i = 0; i < SW; i++) r[i] = ((int'(a[i]) + int'(b[i])) == 0);
        return r;
    endfunction

    function automatic int sat_inc(input int v, input int bits);
        int lim;
        lim = (1 << bits) - 1;
        return (v + 1 > lim) ? lim : v + 1;
    endfunction

    task automatic check_out(input string tag);
        check({tag, ".out_w"}, a_out, ref_nor_w(a_in1, a_in2));
        check({tag, ".out_s"}, s_out, ref_nor_s(s_in1, s_in2));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".q_w"},   a_q,   m_q);
        check({tag, ".cnt_w"}, a_cnt, 64'(m_cnt));
        check({tag, ".err_w"}, a_err, 1'b0);
        check({tag, ".q_s"},   s_q,   ms_q);
        check({tag, ".cnt_s"}, s_cnt, 64'(ms_cnt));
        check({tag, ".err_s"}, s_err, 1'b0);
    endtask

    // Drive both instances, then confirm the combinational output settles in the same step.
    task automatic apply(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [SW-1:0] sx, input logic [SW-1:0] sy);
        a_in1 = x;  a_in2 = y;
        s_in1 = sx; s_in2 = sy;
        #1;
        check_out(tag);
    endtask

    task automatic clock_step(input string tag);
        logic [W-1:0]  nw;
        logic [SW-1:0] ns;
        nw = ref_nor_w(a_in1, a_in2);
        ns = ref_nor_s(s_in1, s_in2);
        @(posedge clk);
        if (nw != m_q) m_cnt = sat_inc(m_cnt, CW);
        if (ns != ms_q) ms_cnt = sat_inc(ms_cnt, SCW);
        m_q  = nw;
        ms_q = ns;
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [W-1:0]  hold_out;
        logic [SW-1:0] hold_s;

        rst = 1'b1;
        a_in1 = '0; a_in2 = '0; s_in1 = '0; s_in2 = '0;
        m_q = '0; m_cnt = 0; ms_q = '0; ms_cnt = 0;
        #2;
        check_out("reset");
        check_regs("reset");
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset_held");

        // Release with out all-ones: the first edge is a transition.
        @(negedge clk);
        rst = 1'b0;
        apply("rel", '0, '0, 1'b0, 1'b0);
        clock_step("rel_edge");

        apply("in2_hi", '0, 8'h01, 1'b0, 1'b1);
        clock_step("in2_hi_edge");

        // Truth-table sweep on the narrow lane; lane pattern 0101/0011 on the wide one.
        for (int k = 0; k < 4; k++) begin
            apply("sweep", 8'h05, 8'h03, SW'(k >> 1), SW'(k & 1));
            clock_step("sweep_edge");
        end

        // Toggle the narrow instance every cycle to drive its 2-bit counter into saturation.
        for (int k = 0; k < 6; k++) begin
            apply("sat", 8'(k), 8'h00, SW'(k & 1), 1'b0);
            clock_step("sat_edge");
        end
        check("sat_value", s_cnt, 2'd3);

        for (int k = 0; k < 40; k++) begin
            apply("rnd", W'($urandom), W'($urandom), SW'($urandom), SW'($urandom));
            clock_step("rnd_edge");
        end

        // Asynchronous reset between edges: registers clear at once, out keeps tracking.
        apply("pre_rst", 8'h0F, 8'h30, 1'b0, 1'b0);
        clock_step("pre_rst_edge");
        #2;
        hold_out = a_out;
        hold_s   = s_out;
        rst = 1'b1;
        #1;
        m_q = '0; m_cnt = 0; ms_q = '0; ms_cnt = 0;
        check_regs("async_rst");
        check("async_rst.out_hold_w", a_out, hold_out);
        check("async_rst.out_hold_s", s_out, hold_s);
        check_out("async_rst");
        #1;
        rst = 1'b0;

        clock_step("post_rst_edge");
        for (int k = 0; k < 20; k++) begin
            apply("rnd2", W'($urandom), W'($urandom), SW'($urandom), SW'($urandom));
            clock_step("rnd2_edge");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
